// File: rtl/char_row_fetch_sched.sv
// char_row_fetch_sched
//   Per-scanline scheduler for the shared character ROM
//   (128 glyphs x 16 rows x 8 bits, addr = {ascii[6:0], row[3:0]}).
//   On line_start it captures v_val and all slot descriptors, then issues
//   one ROM read per slot (slot k in cycle 1+k) and writes the returned
//   glyph row, or 0 for a slot not on this line, to line-buffer index k
//   in cycle 1+k+ROM_LAT.
//
// Parameters
//   NUM_CHARS  slots scanned per line (2..16)
//   IDX_W      width of wr_idx, clog2(NUM_CHARS)
//   ROM_LAT    ROM read latency in clocks (1..3)
//
// Ports
//   clk         system/pixel clock, rising edge
//   reset       asynchronous, active-high
//   line_start  1-cycle pulse, v_val holds the line to prepare
//   v_val       vertical count of the line being prepared
//   slot_en     per-slot enable
//   slot_y      slot k top row at [10k+9:10k]
//   slot_ascii  slot k character at [7k+6:7k]
//   rom_addr    char ROM address (0 when not issuing an active slot)
//   rom_data    char ROM row data, valid ROM_LAT cycles after rom_addr
//   wr_en       line-buffer write strobe
//   wr_idx      line-buffer slot index (holds between writes)
//   wr_data     glyph row bits, MSB = leftmost pixel (holds between writes)
//   busy        high in ISSUE, DRAIN and DONE
//   done        1-cycle pulse once all NUM_CHARS entries are written
//   overrun     sticky: line_start arrived mid-pass; cleared by reset only
//
// Configuration
//   CHAR_SCALE2_EN  when defined, glyphs are double height: 32-line window,
//                   each ROM row spans two lines.
module char_row_fetch_sched #(
  parameter int NUM_CHARS = 8,
  parameter int IDX_W     = 3,
  parameter int ROM_LAT   = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    line_start,
  input  logic [9:0]              v_val,
  input  logic [NUM_CHARS-1:0]    slot_en,
  input  logic [NUM_CHARS*10-1:0] slot_y,
  input  logic [NUM_CHARS*7-1:0]  slot_ascii,
  output logic [10:0]             rom_addr,
  input  logic [7:0]              rom_data,
  output logic                    wr_en,
  output logic [IDX_W-1:0]        wr_idx,
  output logic [7:0]              wr_data,
  output logic                    busy,
  output logic                    done,
  output logic                    overrun
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  localparam logic [IDX_W-1:0] LAST_K = IDX_W'(NUM_CHARS - 1);

  // Window test and row selection. Returns {active, row}. The difference
  // is taken in 11 signed bits so a slot near the bottom of the frame never
  // wraps around onto the top lines.
  function automatic logic [4:0] row_lookup(input logic [9:0] v, input logic [9:0] y);
    logic signed [10:0] d;
    logic               act;
    logic [3:0]         row;
    d = $signed({1'b0, v}) - $signed({1'b0, y});
`ifdef CHAR_SCALE2_EN
    act = !d[10] && (d[9:5] == '0);
    row = 4'hF - d[4:1];
`else
    act = !d[10] && (d[9:4] == '0);
    row = 4'hF - d[3:0];
`endif
    return {act, row};
  endfunction

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        k_q;
  logic                    overrun_q;
  logic [IDX_W-1:0]        wr_idx_q;
  logic [7:0]              wr_data_q;

  logic [9:0]              cap_v;
  logic [NUM_CHARS-1:0]    cap_en;
  logic [NUM_CHARS*10-1:0] cap_y;
  logic [NUM_CHARS*7-1:0]  cap_ascii;

  logic                    issue_p0, act_p0, en_p0, win_p0;
  logic [3:0]              row_p0;
  logic [9:0]              y_p0;
  logic [6:0]              ascii_p0;
  logic                    flush;
  logic                    wr_last;

  logic                    vld_p [1:ROM_LAT];
  logic                    act_p [1:ROM_LAT];
  logic [IDX_W-1:0]        idx_p [1:ROM_LAT];

  // A new line_start during ISSUE/DRAIN abandons the old pass. In DONE the
  // pipeline is already empty, so that case is a normal restart.
  assign flush = line_start && ((state_q == S_ISSUE) || (state_q == S_DRAIN));

  // Input capture: the pass works only from these copies.
  always_ff @(posedge clk) begin
    if (line_start) begin
      cap_v     <= v_val;
      cap_en    <= slot_en;
      cap_y     <= slot_y;
      cap_ascii <= slot_ascii;
    end
  end

  // ---- stage p0: issue slot k_q ----
  always_comb begin
    issue_p0           = (state_q == S_ISSUE);
    y_p0               = cap_y[k_q*10 +: 10];
    ascii_p0           = cap_ascii[k_q*7 +: 7];
    en_p0              = cap_en[k_q];
    {win_p0, row_p0}   = row_lookup(cap_v, y_p0);
    act_p0             = en_p0 && win_p0;
    rom_addr           = (issue_p0 && act_p0) ? {ascii_p0, row_p0} : 11'd0;
  end

  // ---- stages p1..pROM_LAT: tag travels alongside the ROM read ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 1; i <= ROM_LAT; i++) vld_p[i] <= 1'b0;
    end else begin
      vld_p[1] <= issue_p0 && !flush;
      for (int i = 2; i <= ROM_LAT; i++) vld_p[i] <= vld_p[i-1] && !flush;
    end
  end

  always_ff @(posedge clk) begin
    act_p[1] <= act_p0;
    idx_p[1] <= k_q;
    for (int i = 2; i <= ROM_LAT; i++) begin
      act_p[i] <= act_p[i-1];
      idx_p[i] <= idx_p[i-1];
    end
  end

  // ---- write stage: ROM data returns alongside the last tag ----
  always_comb begin
    wr_en   = vld_p[ROM_LAT];
    wr_idx  = wr_en ? idx_p[ROM_LAT] : wr_idx_q;
    wr_data = wr_en ? (act_p[ROM_LAT] ? rom_data : 8'h00) : wr_data_q;
    wr_last = wr_en && (idx_p[ROM_LAT] == LAST_K);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_idx_q  <= '0;
      wr_data_q <= 8'h00;
    end else if (wr_en) begin
      wr_idx_q  <= wr_idx;
      wr_data_q <= wr_data;
    end
  end

  // Control: state, slot counter, sticky overrun.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      k_q       <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (line_start)
        k_q <= '0;
      else if (issue_p0 && (k_q != LAST_K))
        k_q <= k_q + 1'b1;
      if (flush)
        overrun_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (line_start) state_d = S_ISSUE;
      S_ISSUE: begin
        if (line_start)          state_d = S_ISSUE;
        else if (k_q == LAST_K)  state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (line_start)   state_d = S_ISSUE;
        else if (wr_last) state_d = S_DONE;
      end
      S_DONE:  state_d = line_start ? S_ISSUE : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy    = (state_q != S_IDLE);
    done    = (state_q == S_DONE);
    overrun = overrun_q;
  end

endmodule

// File: tb/tb_char_row_fetch_sched.sv
// Testbench for char_row_fetch_sched: a ROM_LAT=1 instance and a ROM_LAT=3
// instance share all stimulus; each has its own behavioural ROM.
module tb_char_row_fetch_sched;

  localparam int NC = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              line_start;
  logic [9:0]        v_val;
  logic [NC-1:0]     slot_en;
  logic [NC*10-1:0]  slot_y;
  logic [NC*7-1:0]   slot_ascii;

  logic [10:0] rom_addr1, rom_addr3;
  logic [7:0]  rom_data1, rom_data3;
  logic        wr_en1, wr_en3;
  logic [2:0]  wr_idx1, wr_idx3;
  logic [7:0]  wr_data1, wr_data3;
  logic        busy1, busy3, done1, done3, overrun1, overrun3;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  char_row_fetch_sched #(.NUM_CHARS(NC), .IDX_W(3), .ROM_LAT(1)) dut1 (
    .clk(clk), .reset(reset), .line_start(line_start), .v_val(v_val),
    .slot_en(slot_en), .slot_y(slot_y), .slot_ascii(slot_ascii),
    .rom_addr(rom_addr1), .rom_data(rom_data1),
    .wr_en(wr_en1), .wr_idx(wr_idx1), .wr_data(wr_data1),
    .busy(busy1), .done(done1), .overrun(overrun1));

  char_row_fetch_sched #(.NUM_CHARS(NC), .IDX_W(3), .ROM_LAT(3)) dut3 (
    .clk(clk), .reset(reset), .line_start(line_start), .v_val(v_val),
    .slot_en(slot_en), .slot_y(slot_y), .slot_ascii(slot_ascii),
    .rom_addr(rom_addr3), .rom_data(rom_data3),
    .wr_en(wr_en3), .wr_idx(wr_idx3), .wr_data(wr_data3),
    .busy(busy3), .done(done3), .overrun(overrun3));

  // Behavioural ROM contents: low address byte XOR {5'b10100, addr[10:8]}.
  function automatic logic [7:0] rom_fn(input logic [10:0] a);
    return a[7:0] ^ {5'b10100, a[10:8]};
  endfunction

  logic [7:0] r3 [0:2];
  always @(posedge clk) begin
    rom_data1 <= rom_fn(rom_addr1);
    r3[0]     <= rom_fn(rom_addr3);
    r3[1]     <= r3[0];
    r3[2]     <= r3[1];
  end
  assign rom_data3 = r3[2];

  // Per-cycle capture, index = cycles after line_start.
  logic [10:0] addr_a [0:31];
  logic        we_a   [0:31];
  logic [2:0]  idx_a  [0:31];
  logic [7:0]  wd_a   [0:31];
  logic        done_a [0:31];
  logic        busy_a [0:31];
  logic        ov_a   [0:31];
  logic        we3_a  [0:31];
  logic [2:0]  idx3_a [0:31];
  logic [7:0]  wd3_a  [0:31];
  logic        done3_a[0:31];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_slot(input int k, input logic en, input logic [9:0] y, input logic [6:0] a);
    slot_en[k]          = en;
    slot_y[k*10 +: 10]  = y;
    slot_ascii[k*7 +: 7] = a;
  endtask

  // Leaves the bench 1 time unit into cycle 1; v_val is scrambled after
  // capture so any use of the live input shows up as wrong addresses.
  task automatic start_line(input logic [9:0] v);
    @(posedge clk); #1;
    line_start = 1'b1;
    v_val      = v;
    @(posedge clk); #1;
    line_start = 1'b0;
    v_val      = 10'h3FF;
  endtask

  // Records cycles 1..ncyc; optionally pulses line_start again in cycle ls_cyc.
  task automatic run_rec(input int ncyc, input int ls_cyc, input logic [9:0] ls_v);
    for (int c = 1; c <= ncyc; c++) begin
      if (c == ls_cyc) begin
        line_start = 1'b1;
        v_val      = ls_v;
      end else if (ls_cyc > 0 && c == ls_cyc + 1) begin
        line_start = 1'b0;
        v_val      = 10'h3FF;
      end
      @(negedge clk);
      addr_a[c]  = rom_addr1;
      we_a[c]    = wr_en1;
      idx_a[c]   = wr_idx1;
      wd_a[c]    = wr_data1;
      done_a[c]  = done1;
      busy_a[c]  = busy1;
      ov_a[c]    = overrun1;
      we3_a[c]   = wr_en3;
      idx3_a[c]  = wr_idx3;
      wd3_a[c]   = wr_data3;
      done3_a[c] = done3;
      @(posedge clk); #1;
    end
  endtask

  int          t3_v    [4] = '{99, 100, 115, 116};
  logic [10:0] t3_addr [4] = '{11'h000, 11'h30F, 11'h300, 11'h000};
  logic [7:0]  t3_wd   [4] = '{8'h00, 8'hAC, 8'hA3, 8'h00};

  int          t4_v    [4] = '{2, 15, 16, 31};
`ifdef CHAR_SCALE2_EN
  logic [10:0] t4_addr [4] = '{11'h7EE, 11'h7E8, 11'h7E7, 11'h7E0};
  logic [7:0]  t4_wd   [4] = '{8'h49, 8'h4F, 8'h40, 8'h47};
`else
  logic [10:0] t4_addr [4] = '{11'h7ED, 11'h7E0, 11'h000, 11'h000};
  logic [7:0]  t4_wd   [4] = '{8'h4A, 8'h47, 8'h00, 8'h00};
`endif

  initial begin
    int nd;
    reset      = 1'b1;
    line_start = 1'b0;
    v_val      = '0;
    slot_en    = '0;
    slot_y     = '0;
    slot_ascii = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rom_addr", 32'(rom_addr1), 32'h0);
    chk("rst_wr_en",    32'(wr_en1),    32'h0);
    chk("rst_wr_idx",   32'(wr_idx1),   32'h0);
    chk("rst_wr_data",  32'(wr_data1),  32'h0);
    chk("rst_busy",     32'(busy1),     32'h0);
    chk("rst_done",     32'(done1),     32'h0);
    chk("rst_overrun",  32'(overrun1),  32'h0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Single active slot 0, remaining slots disabled.
    set_slot(0, 1'b1, 10'd100, 7'h41);
    start_line(10'd100);
    run_rec(13, 0, 10'd0);
    chk("s0_addr_c1",  32'(addr_a[1]), 32'h41F);
    chk("s0_busy_c1",  32'(busy_a[1]), 32'h1);
    chk("s0_we_c2",    32'(we_a[2]),   32'h1);
    chk("s0_idx_c2",   32'(idx_a[2]),  32'h0);
    chk("s0_wd_c2",    32'(wd_a[2]),   32'hBB);
    for (int c = 3; c <= 9; c++) begin
      chk("dis_addr",  32'(addr_a[c-1]), 32'h0);
      chk("dis_we",    32'(we_a[c]),     32'h1);
      chk("dis_idx",   32'(idx_a[c]),    32'(c - 2));
      chk("dis_wd",    32'(wd_a[c]),     32'h0);
    end
    chk("s0_done_c9",  32'(done_a[9]),  32'h0);
    chk("s0_done_c10", 32'(done_a[10]), 32'h1);
    chk("s0_we_c10",   32'(we_a[10]),   32'h0);
    chk("s0_hold_idx", 32'(idx_a[10]),  32'h7);
    chk("s0_busy_c11", 32'(busy_a[11]), 32'h0);
    // ROM_LAT=3: slot k written at cycle 4+k, done at 12.
    chk("l3_we_c3",    32'(we3_a[3]),   32'h0);
    chk("l3_we_c4",    32'(we3_a[4]),   32'h1);
    chk("l3_idx_c4",   32'(idx3_a[4]),  32'h0);
    chk("l3_wd_c4",    32'(wd3_a[4]),   32'hBB);
    chk("l3_idx_c11",  32'(idx3_a[11]), 32'h7);
    chk("l3_done_c11", 32'(done3_a[11]), 32'h0);
    chk("l3_done_c12", 32'(done3_a[12]), 32'h1);

    // Slot 2 window sweep.
    slot_en = '0;
    set_slot(2, 1'b1, 10'd100, 7'h30);
    for (int i = 0; i < 4; i++) begin
      start_line(10'(t3_v[i]));
      run_rec(13, 0, 10'd0);
      chk("sweep_addr", 32'(addr_a[3]), 32'(t3_addr[i]));
      chk("sweep_we",   32'(we_a[4]),   32'h1);
      chk("sweep_wd",   32'(wd_a[4]),   32'(t3_wd[i]));
    end

    // Wrap boundaries: slot 1 near the frame bottom, slot 3 at the top.
    slot_en = '0;
    set_slot(1, 1'b1, 10'd1020, 7'h55);
    set_slot(3, 1'b1, 10'd0,    7'h7E);
    for (int i = 0; i < 4; i++) begin
      start_line(10'(t4_v[i]));
      run_rec(13, 0, 10'd0);
      chk("wrap_y1020_addr", 32'(addr_a[2]), 32'h0);
      chk("wrap_y1020_wd",   32'(wd_a[3]),   32'h0);
      chk("top_y0_addr",     32'(addr_a[4]), 32'(t4_addr[i]));
      chk("top_y0_wd",       32'(wd_a[5]),   32'(t4_wd[i]));
    end

    // line_start in the DONE cycle: clean restart, no overrun.
    slot_en = '0;
    set_slot(0, 1'b1, 10'd100, 7'h41);
    start_line(10'd100);
    run_rec(24, 10, 10'd100);
    chk("dn_done_c10", 32'(done_a[10]), 32'h1);
    chk("dn_ov_c11",   32'(ov_a[11]),   32'h0);
    chk("dn_we_c12",   32'(we_a[12]),   32'h1);
    chk("dn_idx_c12",  32'(idx_a[12]),  32'h0);
    chk("dn_wd_c12",   32'(wd_a[12]),   32'hBB);
    chk("dn_done_c20", 32'(done_a[20]), 32'h1);
    nd = 0;
    for (int c = 1; c <= 24; c++) if (done_a[c]) nd++;
    chk("dn_done_cnt", 32'(nd), 32'd2);

    // line_start mid-pass at cycle 5: overrun, flush, restart.
    start_line(10'd100);
    run_rec(20, 5, 10'd100);
    chk("ov_c5",       32'(ov_a[5]),   32'h0);
    chk("ov_c6",       32'(ov_a[6]),   32'h1);
    chk("ov_we_c5",    32'(we_a[5]),   32'h1);
    chk("ov_idx_c5",   32'(idx_a[5]),  32'h3);
    chk("ov_we_c6",    32'(we_a[6]),   32'h0);
    chk("ov_we_c7",    32'(we_a[7]),   32'h1);
    chk("ov_idx_c7",   32'(idx_a[7]),  32'h0);
    chk("ov_wd_c7",    32'(wd_a[7]),   32'hBB);
    chk("ov_done_c15", 32'(done_a[15]), 32'h1);
    chk("ov_ov_c20",   32'(ov_a[20]),  32'h1);
    nd = 0;
    for (int c = 1; c <= 20; c++) if (done_a[c]) nd++;
    chk("ov_done_cnt", 32'(nd), 32'd1);

    // Reset in cycle 4 of a pass.
    start_line(10'd100);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    chk("mr_rom_addr", 32'(rom_addr1), 32'h0);
    chk("mr_wr_en",    32'(wr_en1),    32'h0);
    chk("mr_wr_idx",   32'(wr_idx1),   32'h0);
    chk("mr_wr_data",  32'(wr_data1),  32'h0);
    chk("mr_busy",     32'(busy1),     32'h0);
    chk("mr_done",     32'(done1),     32'h0);
    chk("mr_overrun",  32'(overrun1),  32'h0);
    chk("mr_l3_wr_en", 32'(wr_en3),    32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    nd = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (wr_en1 || wr_en3 || busy1 || (rom_addr1 != 11'd0)) nd++;
    end
    chk("mr_quiet_after", 32'(nd), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
